// File: rtl/exc_pc_track_if.sv
// Bus bundle for exc_pc_track: pipeline control, PC/BD inputs, CP0 controls
// and the EPC/BD/EXL results. The core side uses the slave modport.
interface exc_pc_track_if #(
  parameter int WIDTH = 32
);
  logic             stall;
  logic             flush;
  logic [WIDTH-1:0] pc_in;
  logic             bd_in;
  logic             valid_in;
  logic             exc_req;
  logic             eret;
  logic             cp0_we;
  logic [WIDTH-1:0] cp0_wdata;
  logic [WIDTH-1:0] victim_pc;
  logic [WIDTH-1:0] epc_out;
  logic             bd_out;
  logic             exl;

  modport master (
    output stall, flush, pc_in, bd_in, valid_in, exc_req, eret, cp0_we, cp0_wdata,
    input  victim_pc, epc_out, bd_out, exl
  );

  modport slave (
    input  stall, flush, pc_in, bd_in, valid_in, exc_req, eret, cp0_we, cp0_wdata,
    output victim_pc, epc_out, bd_out, exl
  );
endinterface

// File: rtl/exc_pc_track.sv
// Exception-PC tracker: shifts PC/BD/valid from decode to commit and latches EPC/BD/EXL.
// Define EXC_PC_BD_ADJUST_EN to back the victim PC up one word for delay-slot instructions.
module exc_pc_track #(
  parameter int               WIDTH    = 32,
  parameter int               STAGES   = 3,
  parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_3000
) (
  input logic         clk,
  input logic         reset,
  exc_pc_track_if.slave bus
);

  logic [WIDTH-1:0]  pc_q [STAGES];
  logic [WIDTH-1:0]  pc_d [STAGES];
  logic [STAGES-1:0] bd_q, bd_d;
  logic [STAGES-1:0] valid_q, valid_d;

  logic [WIDTH-1:0]  epc_q, epc_d;
  logic              bd_out_q, bd_out_d;
  logic              exl_q, exl_d;

  logic [WIDTH-1:0]  aligned_pc;
  logic [WIDTH-1:0]  victim_pc;
  logic              commit_bd;

  // Stalls keep entry 0 and hand a bubble with its PC down the line, so an
  // interrupt landing on the bubble still resumes at the held instruction.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    pc_d    = pc_q;
    bd_d    = bd_q;
    valid_d = valid_q;
    if (bus.flush) begin
      bd_d    = '0;
      valid_d = '0;
    end else if (bus.stall) begin
      for (int i = 2; i < STAGES; i++) begin
        pc_d[i]    = pc_q[i-1];
        bd_d[i]    = bd_q[i-1];
        valid_d[i] = valid_q[i-1];
      end
      pc_d[1]    = pc_q[0];
      bd_d[1]    = bd_q[0];
      valid_d[1] = 1'b0;
    end else begin
      for (int i = 1; i < STAGES; i++) begin
        pc_d[i]    = pc_q[i-1];
        bd_d[i]    = bd_q[i-1];
        valid_d[i] = valid_q[i-1];
      end
      pc_d[0]    = bus.pc_in;
      bd_d[0]    = bus.bd_in;
      valid_d[0] = bus.valid_in;
    end
  end

  assign aligned_pc = {pc_q[STAGES-1][WIDTH-1:2], 2'b00};

`ifdef EXC_PC_BD_ADJUST_EN
  assign commit_bd = bd_q[STAGES-1];
  assign victim_pc = commit_bd ? (aligned_pc - WIDTH'(4)) : aligned_pc;
`else
  assign commit_bd = 1'b0;
  assign victim_pc = aligned_pc;
`endif

  // Nested exceptions leave EPC/BD untouched; EXL simply stays set.
  always_comb begin
    epc_d    = epc_q;
    bd_out_d = bd_out_q;
    exl_d    = exl_q;
    if (bus.exc_req) begin
      if (!exl_q) begin
        epc_d    = victim_pc;
        bd_out_d = commit_bd;
      end
      exl_d = 1'b1;
    end else if (bus.eret) begin
      exl_d = 1'b0;
    end else if (bus.cp0_we) begin
      epc_d = {bus.cp0_wdata[WIDTH-1:2], 2'b00};
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (reset) begin
      for (int i = 0; i < STAGES; i++) pc_q[i] <= RESET_PC;
      bd_q     <= '0;
      valid_q  <= '0;
      epc_q    <= '0;
      bd_out_q <= 1'b0;
      exl_q    <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      bd_q     <= bd_d;
      valid_q  <= valid_d;
      epc_q    <= epc_d;
      bd_out_q <= bd_out_d;
      exl_q    <= exl_d;
    end
  end

  assign bus.victim_pc = victim_pc;
  assign bus.epc_out   = epc_q;
  assign bus.bd_out    = bd_out_q;
  assign bus.exl       = exl_q;

  // Bits that carry no meaning past the commit stage or below word alignment.
  logic unused_bits;
  assign unused_bits = ^{bus.cp0_wdata[1:0], pc_q[STAGES-1][1:0],
                         valid_q[STAGES-1], bd_q[STAGES-1]};

endmodule

// File: tb/tb_exc_pc_track.sv
// Self-checking bench for exc_pc_track: directed test-plan steps then randomized
// traffic against a behavioural model of the PC pipeline and EPC/BD/EXL rules.
module tb_exc_pc_track;
  localparam int          WIDTH    = 32;
  localparam int          STAGES   = 3;
  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  exc_pc_track_if #(.WIDTH(WIDTH)) bus ();

  exc_pc_track #(.WIDTH(WIDTH), .STAGES(STAGES), .RESET_PC(RESET_PC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural model: PC/BD of each tracked stage plus the CP0 view.
  logic [31:0] m_pc [STAGES];
  logic        m_bd [STAGES];
  logic [31:0] m_epc;
  logic        m_bdo;
  logic        m_exl;

  function automatic logic [31:0] m_victim();
    logic [31:0] a;
    a = m_pc[STAGES-1] & ~32'h3;
`ifdef EXC_PC_BD_ADJUST_EN
    if (m_bd[STAGES-1]) a = a - 32'd4;
`endif
    return a;
  endfunction

  task automatic model_clock(input logic rst, input logic stl, input logic fl,
                             input logic [31:0] pc, input logic bd,
                             input logic exc, input logic er, input logic we,
                             input logic [31:0] wd);
    logic [31:0] v;
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        m_pc[i] = RESET_PC;
        m_bd[i] = 1'b0;
      end
      m_epc = '0;
      m_bdo = 1'b0;
      m_exl = 1'b0;
      return;
    end
    v = m_victim();
    if (exc) begin
      if (!m_exl) begin
        m_epc = v;
`ifdef EXC_PC_BD_ADJUST_EN
        m_bdo = m_bd[STAGES-1];
`else
        m_bdo = 1'b0;
`endif
      end
      m_exl = 1'b1;
    end else if (er) begin
      m_exl = 1'b0;
    end else if (we) begin
      m_epc = wd & ~32'h3;
    end
    if (fl) begin
      for (int i = 0; i < STAGES; i++) m_bd[i] = 1'b0;
    end else if (stl) begin
      for (int i = STAGES - 1; i >= 1; i--) begin
        m_pc[i] = m_pc[i-1];
        m_bd[i] = m_bd[i-1];
      end
    end else begin
      for (int i = STAGES - 1; i >= 1; i--) begin
        m_pc[i] = m_pc[i-1];
        m_bd[i] = m_bd[i-1];
      end
      m_pc[0] = pc;
      m_bd[0] = bd;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".victim"}, bus.victim_pc, m_victim());
    check({tag, ".epc"}, bus.epc_out, m_epc);
    check({tag, ".bd_out"}, {31'd0, bus.bd_out}, {31'd0, m_bdo});
    check({tag, ".exl"}, {31'd0, bus.exl}, {31'd0, m_exl});
  endtask

  // One clock: drive inputs, advance model on the edge, compare #1 after it.
  task automatic step(input string tag, input logic rst, input logic stl, input logic fl,
                      input logic [31:0] pc, input logic bd, input logic vld,
                      input logic exc, input logic er, input logic we,
                      input logic [31:0] wd);
    reset         = rst;
    bus.stall     = stl;
    bus.flush     = fl;
    bus.pc_in     = pc;
    bus.bd_in     = bd;
    bus.valid_in  = vld;
    bus.exc_req   = exc;
    bus.eret      = er;
    bus.cp0_we    = we;
    bus.cp0_wdata = wd;
    @(posedge clk);
    model_clock(rst, stl, fl, pc, bd, exc, er, we, wd);
    #1;
    check_all(tag);
  endtask

  task automatic feed(input string tag, input logic [31:0] pc, input logic bd);
    step(tag, 1'b0, 1'b0, 1'b0, pc, bd, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic take_exc(input string tag);
    step(tag, 1'b0, 1'b0, 1'b0, 32'h0000_5000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic do_eret(input string tag);
    step(tag, 1'b0, 1'b0, 1'b0, 32'h0000_5004, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0);
  endtask

  logic [31:0] saved_epc;

  initial begin
    reset = 1'b1;
    bus.stall = 1'b0; bus.flush = 1'b0; bus.pc_in = '0; bus.bd_in = 1'b0;
    bus.valid_in = 1'b0; bus.exc_req = 1'b0; bus.eret = 1'b0; bus.cp0_we = 1'b0;
    bus.cp0_wdata = '0;

    // Reset state
    step("reset", 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    check("reset.victim_const", bus.victim_pc, 32'h0000_3000);
    check("reset.epc_const", bus.epc_out, 32'h0);

    // Basic flow: 0x3000 reaches commit after two more cycles
    feed("flow0", 32'h0000_3000, 1'b0);
    feed("flow1", 32'h0000_3004, 1'b0);
    feed("flow2", 32'h0000_3008, 1'b0);
    check("flow.commit_pc", bus.victim_pc, 32'h0000_3000);
    take_exc("flow.exc");
    check("flow.epc_const", bus.epc_out, 32'h0000_3000);
    check("flow.exl_const", {31'd0, bus.exl}, 32'd1);
    do_eret("flow.eret");

    // Delay-slot instruction with unaligned PC
    feed("ds0", 32'h0000_3011, 1'b1);
    feed("ds1", 32'h0000_3014, 1'b0);
    feed("ds2", 32'h0000_3018, 1'b0);
    take_exc("ds.exc");
`ifdef EXC_PC_BD_ADJUST_EN
    check("ds.epc_const", bus.epc_out, 32'h0000_300C);
    check("ds.bd_const", {31'd0, bus.bd_out}, 32'd1);
`else
    check("ds.epc_const", bus.epc_out, 32'h0000_3010);
    check("ds.bd_const", {31'd0, bus.bd_out}, 32'd0);
`endif
    do_eret("ds.eret");

    // Stall: bubbles inherit the held PC
    feed("st0", 32'h0000_3020, 1'b0);
    step("st.stall1", 1'b0, 1'b1, 1'b0, 32'h0000_3024, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    step("st.stall2", 1'b0, 1'b1, 1'b0, 32'h0000_3024, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    take_exc("st.exc");
    check("st.epc_const", bus.epc_out, 32'h0000_3020);
    do_eret("st.eret");

    // Nested exception leaves EPC alone; ERET keeps EPC
    step("nest.exc1", 1'b0, 1'b0, 1'b0, 32'h0000_4000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    saved_epc = m_epc;
    feed("nest.f1", 32'h0000_4004, 1'b0);
    feed("nest.f2", 32'h0000_4008, 1'b0);
    check("nest.commit_pc", bus.victim_pc, 32'h0000_4000);
    take_exc("nest.exc2");
    check("nest.epc_kept", bus.epc_out, saved_epc);
    do_eret("nest.eret");
    check("nest.epc_after_eret", bus.epc_out, saved_epc);

    // Priority: exc_req beats eret and cp0_we
    feed("pri0", 32'h0000_3040, 1'b0);
    feed("pri1", 32'h0000_3044, 1'b0);
    feed("pri2", 32'h0000_3048, 1'b0);
    step("pri.all", 1'b0, 1'b0, 1'b0, 32'h0000_304C, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_1234);
    check("pri.epc_const", bus.epc_out, 32'h0000_3040);
    do_eret("pri.eret");
    step("pri.eret_we", 1'b0, 1'b0, 1'b0, 32'h0000_3050, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_9998);
    step("pri.we", 1'b0, 1'b0, 1'b0, 32'h0000_3054, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_1237);
    check("pri.we_const", bus.epc_out, 32'h0000_1234);

    // Wraparound: PC 0 in delay slot
    feed("wrap0", 32'h0000_0002, 1'b1);
    feed("wrap1", 32'h0000_0008, 1'b0);
    feed("wrap2", 32'h0000_000C, 1'b0);
`ifdef EXC_PC_BD_ADJUST_EN
    check("wrap.victim_const", bus.victim_pc, 32'hFFFF_FFFC);
`else
    check("wrap.victim_const", bus.victim_pc, 32'h0000_0000);
`endif

    // Flush then exception on the retained PC; then reset mid-run
    step("fl.flush", 1'b0, 1'b1, 1'b1, 32'h0000_6000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    take_exc("fl.exc");
    check("fl.exl_const", {31'd0, bus.exl}, 32'd1);
    step("rst.mid", 1'b1, 1'b0, 1'b0, 32'h0000_7000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_7777);
    check("rst.exl_const", {31'd0, bus.exl}, 32'd0);
    check("rst.epc_const", bus.epc_out, 32'd0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic r_rst, r_stl, r_fl, r_bd, r_vld, r_exc, r_er, r_we;
      logic [31:0] r_pc, r_wd;
      r_rst = ($urandom_range(99) < 2);
      r_stl = ($urandom_range(99) < 20);
      r_fl  = ($urandom_range(99) < 6);
      r_pc  = $urandom;
      r_bd  = 1'($urandom_range(1));
      r_vld = 1'($urandom_range(1));
      r_exc = ($urandom_range(99) < 12);
      r_er  = ($urandom_range(99) < 12);
      r_we  = ($urandom_range(99) < 12);
      r_wd  = $urandom;
      step("rand", r_rst, r_stl, r_fl, r_pc, r_bd, r_vld, r_exc, r_er, r_we, r_wd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/exc_pc_track.md
# exc_pc_track

Exception-PC tracking unit for the pipelined MIPS core. It carries each instruction's PC and delay-slot flag down a parametrised shift pipeline from decode to the commit stage. On an exception or interrupt it computes the word-aligned victim PC and latches it into EPC, backing up by one word for delay-slot instructions. Bubbles inserted by stalls inherit the PC of the held instruction, so interrupts that land on a bubble still resume correctly. Sits beside CP0 and drives EPC, BD and EXL to it and to the NPC mux for ERET.

## Interface
- WIDTH, 32, PC/EPC width in bits (≥ 8)
- STAGES, 3, tracked stages from D to commit (≥ 2); entry STAGES-1 is commit
- RESET_PC, 32'h0000_3000, PC value loaded into every stage entry on reset
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high
- stall  input  1  freeze entry 0; inject bubble into entry 1
- flush  input  1  clear all entries to bubble
- pc_in  input  WIDTH  PC of the instruction entering D
- bd_in  input  1  instruction entering D is in a branch delay slot
- valid_in  input  1  pc_in carries a real instruction
- exc_req  input  1  exception/interrupt taken at commit stage this cycle
- eret  input  1  ERET committing this cycle
- cp0_we  input  1  MTC0 write to EPC
- cp0_wdata  input  WIDTH  MTC0 data
- victim_pc  output  WIDTH  combinational computed EPC of commit entry
- epc_out  output  WIDTH  EPC register, also ERET target
- bd_out  output  1  Cause.BD register
- exl  output  1  exception level flag

## Operation
- Entry fields: pc[WIDTH], bd, valid. Reset: pc=RESET_PC, bd=0, valid=0; epc_out=0, bd_out=0, exl=0.
- Advance (no stall, no flush): entry0 <= {pc_in, bd_in, valid_in}; entry i <= entry i-1.
- Stall: entry0 holds; entry1 <= {entry0.pc, entry0.bd, valid=0}; entries ≥2 advance.
- Flush: all entries valid<=0, bd<=0; pc fields keep their current values. Flush overrides stall.
- Aligned PC = {pc[WIDTH-1:2], 2'b00}. victim_pc = aligned − 4 if commit.bd, else aligned. Subtraction is modulo 2^WIDTH (0 with bd yields all-ones−3).
- Priority on EPC/BD/EXL update: exc_req > eret > cp0_we.
  - exc_req && !exl: epc_out<=victim_pc, bd_out<=commit.bd, exl<=1.
  - exc_req && exl: EPC/BD unchanged (nested), exl stays 1.
  - eret (no exc_req): exl<=0, EPC unchanged.
  - cp0_we (neither above): epc_out<={cp0_wdata[WIDTH-1:2],2'b00}.
- Capture happens on exc_req whether commit entry is valid or a bubble.

## Timing
- Pipeline latency: pc_in reaches commit entry STAGES−1 cycles after acceptance, plus one per stall cycle.
- victim_pc: zero latency from commit entry.
- epc_out/bd_out/exl: registered, visible the cycle after exc_req/eret/cp0_we.
- reset asserted mid-operation overrides all inputs that cycle; state equals reset values the next cycle.

## Configuration
- EXC_PC_BD_ADJUST_EN defined: delay-slot back-up of 4 applied; bd_out captured from commit.bd.
- Not defined: victim_pc = aligned PC always; bd_out held 0; bd fields may be optimised away.

## Test plan
- Reset then 3 cycles pc_in=0x3000,0x3004,0x3008 valid: commit entry pc=0x3000 at cycle 2; exc_req → next cycle epc_out=0x3000, exl=1.
- pc_in=0x3011 with bd_in=1, exc_req at commit → epc_out=0x300C, bd_out=1 (macro on); 0x3010, bd_out=0 (macro off).
- Stall 2 cycles with entry0 pc=0x3020: bubbles carry 0x3020; exc_req on bubble → epc_out=0x3020.
- exl=1, second exc_req with commit pc=0x4000 → epc_out unchanged; then eret → exl=0, epc_out unchanged.
- Same cycle exc_req, eret, cp0_we=0x1234 with commit pc=0x3040 → epc_out=0x3040, exl=1; later cp0_we alone data 0x1237 → epc_out=0x1234.
- flush then exc_req next cycle → commit.valid=0, victim_pc from retained pc; reset mid-run clears exl/epc_out to 0.
